// File: rtl/mor1kx_store_buffer_fwd.sv
// Store buffer between the LSU and the data bus.
// Show-ahead FIFO of pending stores, built from registers so the head is readable with no latency.
// A store to the same word as the youngest entry is merged into that entry (write combining).
// Loads probe the forward port and get byte-granular data from the pending stores.
module mor1kx_store_buffer_fwd #(
   parameter int DEPTH_WIDTH          = 3,
   parameter int OPTION_OPERAND_WIDTH = 32,
   parameter int FEATURE_COMBINE      = 1,
   parameter int FEATURE_FORWARD      = 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [OPTION_OPERAND_WIDTH-1:0]     pc_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0]     adr_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0]     dat_i,
   input  logic [OPTION_OPERAND_WIDTH/8-1:0]   bsel_i,
   input  logic                                atomic_i,
   input  logic                                write_i,
   input  logic                                read_i,
   output logic [OPTION_OPERAND_WIDTH-1:0]     pc_o,
   output logic [OPTION_OPERAND_WIDTH-1:0]     adr_o,
   output logic [OPTION_OPERAND_WIDTH-1:0]     dat_o,
   output logic [OPTION_OPERAND_WIDTH/8-1:0]   bsel_o,
   output logic                                atomic_o,
   input  logic [OPTION_OPERAND_WIDTH-1:0]     fwd_adr_i,
   output logic                                fwd_hit_o,
   output logic [OPTION_OPERAND_WIDTH/8-1:0]   fwd_bsel_o,
   output logic [OPTION_OPERAND_WIDTH-1:0]     fwd_dat_o,
   output logic                                full_o,
   output logic                                empty_o,
   output logic [DEPTH_WIDTH:0]                count_o
);

   localparam int W     = OPTION_OPERAND_WIDTH;
   localparam int B     = W / 8;
   localparam int LSB   = $clog2(B);
   localparam int DEPTH = 1 << DEPTH_WIDTH;
   localparam logic [DEPTH_WIDTH:0] DEPTH_CNT = {1'b1, {DEPTH_WIDTH{1'b0}}};

   // Entry storage; each field kept in its own register array
   logic [W-1:0] adr_q    [DEPTH];
   logic [W-1:0] adr_d    [DEPTH];
   logic [W-1:0] dat_q    [DEPTH];
   logic [W-1:0] dat_d    [DEPTH];
   logic [B-1:0] bsel_q   [DEPTH];
   logic [B-1:0] bsel_d   [DEPTH];
   logic [W-1:0] pc_q     [DEPTH];
   logic [W-1:0] pc_d     [DEPTH];
   logic         atomic_q [DEPTH];
   logic         atomic_d [DEPTH];

   logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_WIDTH:0]   count_q, count_d;

   logic                   empty;
   logic                   full;
   logic [DEPTH_WIDTH-1:0] tail_idx;
   logic                   tail_match;
   logic                   do_pop;
   logic                   do_merge;
   logic                   do_alloc;

   assign empty    = (count_q == '0);
   assign full     = (count_q == DEPTH_CNT);
   assign tail_idx = wr_ptr_q - 1'b1;

   // Only the word part of the address matters; byte offsets within a word are covered by bsel
   assign tail_match = (adr_q[tail_idx][W-1:LSB] == adr_i[W-1:LSB]);

   // Classify this cycle's operations: pop, merge into tail, or allocate a new entry
   always_comb begin
      do_pop   = read_i && !empty;
      do_merge = (FEATURE_COMBINE != 0) && write_i && !atomic_i && !empty &&
                 !atomic_q[tail_idx] && tail_match &&
                 !(read_i && (count_q == {{DEPTH_WIDTH{1'b0}}, 1'b1}));
      // A full buffer only accepts a new entry when the head leaves in the same cycle;
      // otherwise the store is dropped and the state is left untouched.
      do_alloc = write_i && !do_merge && (!full || read_i);
   end

   // Next-state for entry storage, pointers and occupancy
   always_comb begin
      adr_d    = adr_q;
      dat_d    = dat_q;
      bsel_d   = bsel_q;
      pc_d     = pc_q;
      atomic_d = atomic_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;

      if (do_merge) begin
         for (int b = 0; b < B; b++) begin
            if (bsel_i[b]) begin
               dat_d[tail_idx][8*b +: 8] = dat_i[8*b +: 8];
            end
         end
         bsel_d[tail_idx] = bsel_q[tail_idx] | bsel_i;
      end

      if (do_alloc) begin
         adr_d[wr_ptr_q]    = adr_i;
         dat_d[wr_ptr_q]    = dat_i;
         bsel_d[wr_ptr_q]   = bsel_i;
         pc_d[wr_ptr_q]     = pc_i;
         atomic_d[wr_ptr_q] = atomic_i;
         wr_ptr_d           = wr_ptr_q + 1'b1;
      end

      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      // Push and pop in the same cycle cancel out
      if (do_alloc && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (!do_alloc && do_pop) begin
         count_d = count_q - 1'b1;
      end
   end

   // State registers; reset clears every pending store
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            adr_q[i]    <= '0;
            dat_q[i]    <= '0;
            bsel_q[i]   <= '0;
            pc_q[i]     <= '0;
            atomic_q[i] <= 1'b0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         bsel_q   <= bsel_d;
         pc_q     <= pc_d;
         atomic_q <= atomic_d;
      end
   end

   // Head of the FIFO is presented directly from storage (show-ahead)
   assign pc_o     = pc_q[rd_ptr_q];
   assign adr_o    = adr_q[rd_ptr_q];
   assign dat_o    = dat_q[rd_ptr_q];
   assign bsel_o   = bsel_q[rd_ptr_q];
   assign atomic_o = atomic_q[rd_ptr_q];
   assign full_o   = full;
   assign empty_o  = empty;
   assign count_o  = count_q;

   // Forwarding scan from oldest to youngest so later stores overwrite earlier lanes.
   // Only registered entries are seen; a store arriving this cycle is not yet visible.
   logic         fwd_hit;
   logic [B-1:0] fwd_bsel;
   logic [W-1:0] fwd_dat;

   always_comb begin
      logic [DEPTH_WIDTH-1:0] idx;
      fwd_hit  = 1'b0;
      fwd_bsel = '0;
      fwd_dat  = '0;
      idx      = '0;
      if (FEATURE_FORWARD != 0) begin
         for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + k[DEPTH_WIDTH-1:0];
            if ((k < int'(count_q)) && (adr_q[idx][W-1:LSB] == fwd_adr_i[W-1:LSB])) begin
               fwd_hit = 1'b1;
               for (int b = 0; b < B; b++) begin
                  if (bsel_q[idx][b]) begin
                     fwd_bsel[b]          = 1'b1;
                     fwd_dat[8*b +: 8]    = dat_q[idx][8*b +: 8];
                  end
               end
            end
         end
      end
   end

   assign fwd_hit_o  = fwd_hit;
   assign fwd_bsel_o = fwd_bsel;
   assign fwd_dat_o  = fwd_dat;

   // Byte offset of the probe address has no effect on the word match
   generate
      if (LSB > 0) begin : g_unused_lsb
         logic unused_fwd_lsb;
         assign unused_fwd_lsb = ^fwd_adr_i[LSB-1:0];
      end
   endgenerate

endmodule

// File: tb/tb_mor1kx_store_buffer_fwd.sv
// Self-checking bench for the store buffer: scoreboard of expected head entries
// plus directed checks of occupancy, combining and forwarding.
module tb_mor1kx_store_buffer_fwd;

   logic        clk;
   logic        rst;
   logic [31:0] pc_i, adr_i, dat_i, fwd_adr_i;
   logic [3:0]  bsel_i;
   logic        atomic_i, write_i, read_i;
   logic [31:0] pc_o, adr_o, dat_o, fwd_dat_o;
   logic [3:0]  bsel_o, fwd_bsel_o;
   logic        atomic_o, fwd_hit_o, full_o, empty_o;
   logic [3:0]  count_o;

   // Second instance with combining disabled, sharing all inputs
   logic [31:0] nc_pc_o, nc_adr_o, nc_dat_o, nc_fwd_dat_o;
   logic [3:0]  nc_bsel_o, nc_fwd_bsel_o;
   logic        nc_atomic_o, nc_fwd_hit_o, nc_full_o, nc_empty_o;
   logic [3:0]  nc_count_o;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  bsel;
      logic        atomic;
      logic [31:0] pc;
   } ent_t;

   ent_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   mor1kx_store_buffer_fwd #(
      .DEPTH_WIDTH(3), .OPTION_OPERAND_WIDTH(32), .FEATURE_COMBINE(1), .FEATURE_FORWARD(1)
   ) u_dut (
      .clk(clk), .rst(rst), .pc_i(pc_i), .adr_i(adr_i), .dat_i(dat_i), .bsel_i(bsel_i),
      .atomic_i(atomic_i), .write_i(write_i), .read_i(read_i),
      .pc_o(pc_o), .adr_o(adr_o), .dat_o(dat_o), .bsel_o(bsel_o), .atomic_o(atomic_o),
      .fwd_adr_i(fwd_adr_i), .fwd_hit_o(fwd_hit_o), .fwd_bsel_o(fwd_bsel_o),
      .fwd_dat_o(fwd_dat_o), .full_o(full_o), .empty_o(empty_o), .count_o(count_o)
   );

   mor1kx_store_buffer_fwd #(
      .DEPTH_WIDTH(3), .OPTION_OPERAND_WIDTH(32), .FEATURE_COMBINE(0), .FEATURE_FORWARD(1)
   ) u_nc (
      .clk(clk), .rst(rst), .pc_i(pc_i), .adr_i(adr_i), .dat_i(dat_i), .bsel_i(bsel_i),
      .atomic_i(atomic_i), .write_i(write_i), .read_i(read_i),
      .pc_o(nc_pc_o), .adr_o(nc_adr_o), .dat_o(nc_dat_o), .bsel_o(nc_bsel_o),
      .atomic_o(nc_atomic_o), .fwd_adr_i(fwd_adr_i), .fwd_hit_o(nc_fwd_hit_o),
      .fwd_bsel_o(nc_fwd_bsel_o), .fwd_dat_o(nc_fwd_dat_o), .full_o(nc_full_o),
      .empty_o(nc_empty_o), .count_o(nc_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] pcof(input logic [31:0] a);
      return a ^ 32'hC000_0000;
   endfunction

   function automatic ent_t mk(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] b, input logic at);
      ent_t e;
      e.adr = a; e.dat = d; e.bsel = b; e.atomic = at; e.pc = pcof(a);
      return e;
   endfunction

   // Advance one clock; leave the bench 1 time unit after the rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] b, input logic at);
      adr_i = a; dat_i = d; bsel_i = b; atomic_i = at; pc_i = pcof(a);
   endtask

   // Reset while the design may hold state; checks the asynchronous clear before any clock edge
   task automatic do_reset();
      rst = 1'b1;
      #2;
      n_vec++;
      if (count_o !== 4'd0 || empty_o !== 1'b1 || adr_o !== 32'h0 || fwd_hit_o !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: count=%0d empty=%b adr=%h hit=%b, required 0/1/0/0",
                  count_o, empty_o, adr_o, fwd_hit_o);
      end
      cyc();
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic at);
      set_store(a, d, b, at);
      write_i = 1'b1;
      cyc();
      write_i = 1'b0;
      $display("wr  adr=%h dat=%h bsel=%h atomic=%b -> count=%0d", a, d, b, at, count_o);
   endtask

   // Compare the head against the scoreboard, then pop it
   task automatic rd();
      ent_t e;
      if (sb.size() == 0) begin
         n_vec++; n_err++;
         $display("FAIL rd_underflow: scoreboard empty, dut count=%0d", count_o);
         return;
      end
      e = sb.pop_front();
      n_vec++;
      if (adr_o !== e.adr || dat_o !== e.dat || bsel_o !== e.bsel ||
          atomic_o !== e.atomic || pc_o !== e.pc || empty_o !== 1'b0) begin
         n_err++;
         $display("FAIL head: got adr=%h dat=%h bsel=%h at=%b pc=%h empty=%b, required adr=%h dat=%h bsel=%h at=%b pc=%h empty=0",
                  adr_o, dat_o, bsel_o, atomic_o, pc_o, empty_o, e.adr, e.dat, e.bsel, e.atomic, e.pc);
      end
      read_i = 1'b1;
      cyc();
      read_i = 1'b0;
      $display("rd  adr=%h dat=%h bsel=%h -> count=%0d", e.adr, e.dat, e.bsel, count_o);
   endtask

   // Simultaneous push and pop: check head, then write a new store while popping
   task automatic wr_rd(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input ent_t exp_new);
      ent_t e;
      e = sb.pop_front();
      n_vec++;
      if (adr_o !== e.adr || dat_o !== e.dat || bsel_o !== e.bsel) begin
         n_err++;
         $display("FAIL wr_rd_head: got adr=%h dat=%h bsel=%h, required adr=%h dat=%h bsel=%h",
                  adr_o, dat_o, bsel_o, e.adr, e.dat, e.bsel);
      end
      sb.push_back(exp_new);
      set_store(a, d, b, 1'b0);
      write_i = 1'b1;
      read_i  = 1'b1;
      cyc();
      write_i = 1'b0;
      read_i  = 1'b0;
      $display("wr+rd adr=%h -> count=%0d", a, count_o);
   endtask

   task automatic drain();
      while (sb.size() != 0) rd();
      n_vec++;
      if (empty_o !== 1'b1 || count_o !== 4'd0) begin
         n_err++;
         $display("FAIL drain_empty: empty=%b count=%0d, required 1/0", empty_o, count_o);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
      n_vec++;
      if (empty_o !== 1'b1 || full_o !== 1'b0 || count_o !== 4'd0 ||
          fwd_hit_o !== 1'b0 || adr_o !== 32'h0 || fwd_dat_o !== 32'h0) begin
         n_err++;
         $display("FAIL reset: empty=%b full=%b count=%0d hit=%b adr=%h fdat=%h, required 1/0/0/0/0/0",
                  empty_o, full_o, count_o, fwd_hit_o, adr_o, fwd_dat_o);
      end
   endtask

   task automatic test_basic();
      do_reset();
      wr(32'h100, 32'h1122_3344, 4'hF, 1'b0);
      sb.push_back(mk(32'h100, 32'h1122_3344, 4'hF, 1'b0));
      wr(32'h104, 32'h5566_7788, 4'hF, 1'b0);
      sb.push_back(mk(32'h104, 32'h5566_7788, 4'hF, 1'b0));
      n_vec++;
      if (count_o !== 4'd2 || adr_o !== 32'h100) begin
         n_err++;
         $display("FAIL basic_count: count=%0d adr=%h, required 2/00000100", count_o, adr_o);
      end
      drain();
   endtask

   task automatic test_combine();
      do_reset();
      wr(32'h200, 32'h0000_00AA, 4'h1, 1'b0);
      wr(32'h202, 32'hBBBB_0000, 4'hC, 1'b0);
      sb.push_back(mk(32'h200, 32'hBBBB_00AA, 4'hD, 1'b0));
      n_vec++;
      if (count_o !== 4'd1 || dat_o !== 32'hBBBB_00AA || bsel_o !== 4'hD) begin
         n_err++;
         $display("FAIL combine: count=%0d dat=%h bsel=%h, required 1/bbbb00aa/d",
                  count_o, dat_o, bsel_o);
      end
      n_vec++;
      if (nc_count_o !== 4'd2) begin
         n_err++;
         $display("FAIL no_combine_param: count=%0d, required 2", nc_count_o);
      end
      drain();
   endtask

   task automatic test_atomic();
      do_reset();
      wr(32'h200, 32'h0000_00AA, 4'h1, 1'b0);
      sb.push_back(mk(32'h200, 32'h0000_00AA, 4'h1, 1'b0));
      wr(32'h202, 32'hBBBB_0000, 4'hC, 1'b1);
      sb.push_back(mk(32'h202, 32'hBBBB_0000, 4'hC, 1'b1));
      n_vec++;
      if (count_o !== 4'd2) begin
         n_err++;
         $display("FAIL atomic_no_merge: count=%0d, required 2", count_o);
      end
      // Tail is atomic now, so a plain store to the same word must not merge into it
      wr(32'h201, 32'h0000_CC00, 4'h2, 1'b0);
      sb.push_back(mk(32'h201, 32'h0000_CC00, 4'h2, 1'b0));
      n_vec++;
      if (count_o !== 4'd3) begin
         n_err++;
         $display("FAIL atomic_tail: count=%0d, required 3", count_o);
      end
      drain();
   endtask

   task automatic test_full_wrap();
      ent_t e;
      do_reset();
      // Move pointers off zero so the fill wraps around
      for (int i = 0; i < 3; i++) begin
         wr(32'h500 + 32'(i) * 32'h10, 32'hA0 + 32'(i), 4'hF, 1'b0);
         sb.push_back(mk(32'h500 + 32'(i) * 32'h10, 32'hA0 + 32'(i), 4'hF, 1'b0));
      end
      drain();
      for (int i = 0; i < 8; i++) begin
         wr(32'h1000 + 32'(i) * 32'h10, 32'hD000_0000 + 32'(i), 4'hF, 1'b0);
         sb.push_back(mk(32'h1000 + 32'(i) * 32'h10, 32'hD000_0000 + 32'(i), 4'hF, 1'b0));
      end
      n_vec++;
      if (full_o !== 1'b1 || count_o !== 4'd8) begin
         n_err++;
         $display("FAIL fill: full=%b count=%0d, required 1/8", full_o, count_o);
      end
      // Allocation into a full buffer without a pop is dropped
      wr(32'h2000, 32'hDEAD_BEEF, 4'hF, 1'b0);
      n_vec++;
      if (count_o !== 4'd8 || full_o !== 1'b1 || adr_o !== 32'h1000) begin
         n_err++;
         $display("FAIL full_drop: count=%0d full=%b head=%h, required 8/1/00001000",
                  count_o, full_o, adr_o);
      end
      wr_rd(32'h3000, 32'h3000_0000, 4'hF, mk(32'h3000, 32'h3000_0000, 4'hF, 1'b0));
      wr_rd(32'h3010, 32'h3333_3333, 4'h3, mk(32'h3010, 32'h3333_3333, 4'h3, 1'b0));
      n_vec++;
      if (count_o !== 4'd8 || full_o !== 1'b1) begin
         n_err++;
         $display("FAIL full_pushpop: count=%0d full=%b, required 8/1", count_o, full_o);
      end
      // Combining is allowed while full
      wr(32'h3012, 32'h00EE_0000, 4'h4, 1'b0);
      e = sb[sb.size()-1];
      e.dat  = 32'h33EE_3333;
      e.bsel = 4'h7;
      sb[sb.size()-1] = e;
      n_vec++;
      if (count_o !== 4'd8) begin
         n_err++;
         $display("FAIL full_merge: count=%0d, required 8", count_o);
      end
      drain();
   endtask

   task automatic test_pushpop_one();
      do_reset();
      wr(32'h400, 32'h0000_0001, 4'h1, 1'b0);
      sb.push_back(mk(32'h400, 32'h0000_0001, 4'h1, 1'b0));
      wr_rd(32'h400, 32'h0000_0200, 4'h2, mk(32'h400, 32'h0000_0200, 4'h2, 1'b0));
      n_vec++;
      if (count_o !== 4'd1 || bsel_o !== 4'h2 || dat_o !== 32'h0000_0200) begin
         n_err++;
         $display("FAIL pushpop_one: count=%0d bsel=%h dat=%h, required 1/2/00000200",
                  count_o, bsel_o, dat_o);
      end
      drain();
   endtask

   task automatic test_forward();
      do_reset();
      wr(32'h300, 32'h0000_1111, 4'h3, 1'b0);
      sb.push_back(mk(32'h300, 32'h0000_1111, 4'h3, 1'b0));
      wr(32'h304, 32'hCAFE_F00D, 4'hF, 1'b0);
      sb.push_back(mk(32'h304, 32'hCAFE_F00D, 4'hF, 1'b0));
      wr(32'h300, 32'h0000_2200, 4'h2, 1'b0);
      sb.push_back(mk(32'h300, 32'h0000_2200, 4'h2, 1'b0));
      fwd_adr_i = 32'h301;
      #1;
      n_vec++;
      if (fwd_hit_o !== 1'b1 || fwd_bsel_o !== 4'h3 || fwd_dat_o !== 32'h0000_2211) begin
         n_err++;
         $display("FAIL fwd_youngest: hit=%b bsel=%h dat=%h, required 1/3/00002211",
                  fwd_hit_o, fwd_bsel_o, fwd_dat_o);
      end
      fwd_adr_i = 32'h306;
      #1;
      n_vec++;
      if (fwd_hit_o !== 1'b1 || fwd_bsel_o !== 4'hF || fwd_dat_o !== 32'hCAFE_F00D) begin
         n_err++;
         $display("FAIL fwd_full_word: hit=%b bsel=%h dat=%h, required 1/f/cafef00d",
                  fwd_hit_o, fwd_bsel_o, fwd_dat_o);
      end
      // Store arriving this cycle must not be forwarded until it is registered
      fwd_adr_i = 32'h308;
      set_store(32'h308, 32'h1234_5678, 4'hF, 1'b0);
      write_i = 1'b1;
      #1;
      n_vec++;
      if (fwd_hit_o !== 1'b0 || fwd_bsel_o !== 4'h0 || fwd_dat_o !== 32'h0) begin
         n_err++;
         $display("FAIL fwd_same_cycle: hit=%b bsel=%h dat=%h, required 0/0/0",
                  fwd_hit_o, fwd_bsel_o, fwd_dat_o);
      end
      cyc();
      write_i = 1'b0;
      sb.push_back(mk(32'h308, 32'h1234_5678, 4'hF, 1'b0));
      n_vec++;
      if (fwd_hit_o !== 1'b1 || fwd_dat_o !== 32'h1234_5678) begin
         n_err++;
         $display("FAIL fwd_after_write: hit=%b dat=%h, required 1/12345678", fwd_hit_o, fwd_dat_o);
      end
      // Entry being popped stays visible this cycle, gone afterwards
      fwd_adr_i = 32'h300;
      void'(sb.pop_front());
      read_i = 1'b1;
      #1;
      n_vec++;
      if (fwd_bsel_o !== 4'h3 || fwd_dat_o !== 32'h0000_2211) begin
         n_err++;
         $display("FAIL fwd_popping: bsel=%h dat=%h, required 3/00002211", fwd_bsel_o, fwd_dat_o);
      end
      cyc();
      read_i = 1'b0;
      n_vec++;
      if (fwd_hit_o !== 1'b1 || fwd_bsel_o !== 4'h2 || fwd_dat_o !== 32'h0000_2200) begin
         n_err++;
         $display("FAIL fwd_after_pop: hit=%b bsel=%h dat=%h, required 1/2/00002200",
                  fwd_hit_o, fwd_bsel_o, fwd_dat_o);
      end
      fwd_adr_i = 32'h0;
      // Reset with stores pending discards them (checked inside do_reset)
      do_reset();
      n_vec++;
      if (empty_o !== 1'b1 || fwd_hit_o !== 1'b0 || dat_o !== 32'h0) begin
         n_err++;
         $display("FAIL reset_mid: empty=%b hit=%b dat=%h, required 1/0/0", empty_o, fwd_hit_o, dat_o);
      end
   endtask

   initial begin
      rst = 1'b1;
      pc_i = '0; adr_i = '0; dat_i = '0; bsel_i = '0; atomic_i = 1'b0;
      write_i = 1'b0; read_i = 1'b0; fwd_adr_i = '0;
      test_reset();
      test_basic();
      test_combine();
      test_atomic();
      test_full_wrap();
      test_pushpop_one();
      test_forward();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

endmodule
